// File: rtl/kinase_array_sequencer_if.sv
// kinase_array_sequencer_if: host-side command bus and valve-bank outputs of the kinase array sequencer
// Ports (master = host, slave = sequencer):
//   start, abort, ch_mask, load/mix/incub/flush_cycles  host -> sequencer
//   repeats (KINASE_SEQ_REPEAT_EN only)                  host -> sequencer, extra MIX/INCUBATE passes
//   ctrl, sieve, pump, inlet_en                          sequencer -> solenoid bank
//   busy, phase, done, aborted, err                      sequencer -> host status
interface kinase_array_sequencer_if #(
    parameter int NUM_CH  = 2,
    parameter int TIMER_W = 16,
    parameter int PUMP_W  = 5
);
    logic               start;
    logic               abort;
    logic [NUM_CH-1:0]  ch_mask;
    logic [TIMER_W-1:0] load_cycles;
    logic [TIMER_W-1:0] mix_cycles;
    logic [TIMER_W-1:0] incub_cycles;
    logic [TIMER_W-1:0] flush_cycles;
`ifdef KINASE_SEQ_REPEAT_EN
    logic [3:0]         repeats;
`endif
    logic [12:0]        ctrl;
    logic [3:0]         sieve;
    logic [PUMP_W-1:0]  pump;
    logic [NUM_CH-1:0]  inlet_en;
    logic               busy;
    logic [2:0]         phase;
    logic               done;
    logic               aborted;
    logic               err;

    modport master (
`ifdef KINASE_SEQ_REPEAT_EN
        output repeats,
`endif
        output start, abort, ch_mask, load_cycles, mix_cycles, incub_cycles, flush_cycles,
        input  ctrl, sieve, pump, inlet_en, busy, phase, done, aborted, err
    );

    modport slave (
`ifdef KINASE_SEQ_REPEAT_EN
        input  repeats,
`endif
        input  start, abort, ch_mask, load_cycles, mix_cycles, incub_cycles, flush_cycles,
        output ctrl, sieve, pump, inlet_en, busy, phase, done, aborted, err
    );
endinterface

// File: rtl/kinase_array_sequencer.sv
// kinase_array_sequencer: timed LOAD/MIX/INCUBATE/FLUSH/DONE valve sequencer for a shared-valve kinase assay array
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    kinase_array_sequencer_if.slave: host commands in, registered valve lines and status out
// Optional feature: define KINASE_SEQ_REPEAT_EN to add bus.repeats, the number of extra
// MIX/INCUBATE passes run before FLUSH (the name avoids the SV keyword "repeat").
module kinase_array_sequencer #(
    parameter int NUM_CH   = 2,
    parameter int TIMER_W  = 16,
    parameter int PUMP_W   = 5,
    parameter int PUMP_DIV = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    kinase_array_sequencer_if.slave  bus
);
    localparam int DIV_W = PUMP_DIV > 1 ? $clog2(PUMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MIX   = 3'd2,
        INCUB = 3'd3,
        FLUSH = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [NUM_CH-1:0]  mask_l;
    logic [TIMER_W-1:0] mix_l, incub_l, flush_l, cnt, cnt_n, dur;
    logic [DIV_W-1:0]   pdiv, pdiv_n;
    logic [PUMP_W-1:0]  pump_n;
    logic               start_ok, abort_ok, fin, entering, pumping, err_n;
`ifdef KINASE_SEQ_REPEAT_EN
    logic [3:0]         rep_l, pass, pass_n;
`endif

    always_comb begin
        start_ok = bus.start && |bus.ch_mask;
        abort_ok = bus.abort && (state == LOAD || state == MIX || state == INCUB);
        err_n    = state == IDLE && bus.start && ~|bus.ch_mask;
        fin      = cnt == '0;
        state_n  = state;
`ifdef KINASE_SEQ_REPEAT_EN
        pass_n   = pass;
`endif
        case (state)
            IDLE: begin
                if (start_ok) state_n = LOAD;
`ifdef KINASE_SEQ_REPEAT_EN
                if (start_ok) pass_n = '0;
`endif
            end
            LOAD:  if (fin) state_n = MIX;
            MIX:   if (fin) state_n = INCUB;
            INCUB: begin
`ifdef KINASE_SEQ_REPEAT_EN
                if (fin && pass != rep_l) begin
                    state_n = MIX;
                    pass_n  = pass + 4'd1;
                end else if (fin) state_n = FLUSH;
`else
                if (fin) state_n = FLUSH;
`endif
            end
            FLUSH: if (fin) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort beats a coinciding phase end and discards any remaining passes
        if (abort_ok) state_n = FLUSH;
        entering = state_n != state;
        pumping  = state_n == MIX || state_n == FLUSH;
        // LOAD is only entered from IDLE, so its duration comes straight from the bus
        dur      = state_n == LOAD ? bus.load_cycles : state_n == MIX ? mix_l :
                   state_n == INCUB ? incub_l : flush_l;
        // timer counts down to zero; a zero duration still gives one cycle
        cnt_n    = entering ? (dur == '0 ? '0 : dur - TIMER_W'(1)) : cnt - TIMER_W'(1);
        pdiv_n   = (entering || pdiv == DIV_LAST) ? '0 : pdiv + DIV_W'(1);
        pump_n   = !pumping ? '1 : entering ? ~PUMP_W'(1) :
                   pdiv == DIV_LAST ? {bus.pump[PUMP_W-2:0], bus.pump[PUMP_W-1]} : bus.pump;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pdiv         <= '0;
            mask_l       <= '0;
            mix_l        <= '0;
            incub_l      <= '0;
            flush_l      <= '0;
`ifdef KINASE_SEQ_REPEAT_EN
            rep_l        <= '0;
            pass         <= '0;
`endif
            bus.ctrl     <= 13'h1FFF;
            bus.sieve    <= 4'h0;
            bus.pump     <= '1;
            bus.inlet_en <= '0;
            bus.busy     <= 1'b0;
            bus.phase    <= 3'd0;
            bus.done     <= 1'b0;
            bus.aborted  <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pdiv         <= pdiv_n;
`ifdef KINASE_SEQ_REPEAT_EN
            pass         <= pass_n;
`endif
            if (state == IDLE && start_ok) begin
                mask_l      <= bus.ch_mask;
                mix_l       <= bus.mix_cycles;
                incub_l     <= bus.incub_cycles;
                flush_l     <= bus.flush_cycles;
`ifdef KINASE_SEQ_REPEAT_EN
                rep_l       <= bus.repeats;
`endif
                bus.aborted <= 1'b0;
            end
            if (abort_ok) bus.aborted <= 1'b1;
            bus.ctrl     <= state_n == LOAD ? 13'h1FF0 : state_n == MIX ? 13'h1E0F :
                            state_n == FLUSH ? 13'h01FF : 13'h1FFF;
            bus.sieve    <= (state_n == LOAD || state_n == MIX || state_n == INCUB) ? 4'hF : 4'h0;
            bus.pump     <= pump_n;
            bus.inlet_en <= state_n != LOAD ? '0 : state == IDLE ? bus.ch_mask : mask_l;
            bus.busy     <= state_n != IDLE;
            bus.phase    <= state_n;
            bus.done     <= state_n == DONE;
            bus.err      <= err_n;
        end
    end
endmodule

// File: tb/tb_kinase_array_sequencer.sv
// tb_kinase_array_sequencer: self-checking bench with a per-cycle schedule model and directed vectors
module tb_kinase_array_sequencer;
    localparam int NUM_CH   = 2;
    localparam int TIMER_W  = 16;
    localparam int PUMP_W   = 5;
    localparam int PUMP_DIV = 4;

    typedef struct {
        int ph;
        int k;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cmp_n = 0;
    int   fail_n = 0;

    kinase_array_sequencer_if #(.NUM_CH(NUM_CH), .TIMER_W(TIMER_W), .PUMP_W(PUMP_W)) bus ();

    kinase_array_sequencer #(
        .NUM_CH(NUM_CH), .TIMER_W(TIMER_W), .PUMP_W(PUMP_W), .PUMP_DIV(PUMP_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        cmp_n++;
        if (got !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: the expected run is a queue with one entry per busy cycle; the head is what the
    // outputs show this cycle. An empty queue means IDLE.
    ent_t              q[$];
    logic [NUM_CH-1:0] m_mask;
    int                m_flush, m_rep, eph, ek, cph;
    logic              m_ab = 1'b0;
    logic              m_err = 1'b0;
    logic [12:0]       e_ctrl;
    logic [PUMP_W-1:0] e_pump;

    task automatic add(input int ph, input int d);
        int n = d == 0 ? 1 : d;
        for (int k = 0; k < n; k++) q.push_back('{ph, k});
    endtask

    always @(negedge clk) begin
        eph = q.size() == 0 ? 0 : q[0].ph;
        ek  = q.size() == 0 ? 0 : q[0].k;
        e_ctrl = eph == 1 ? 13'h1FF0 : eph == 2 ? 13'h1E0F : eph == 4 ? 13'h01FF : 13'h1FFF;
        e_pump = '1;
        if (eph == 2 || eph == 4) e_pump[(ek / PUMP_DIV) % PUMP_W] = 1'b0;
        check("phase", bus.phase, eph);
        check("busy", bus.busy, q.size() != 0);
        check("ctrl", bus.ctrl, e_ctrl);
        check("sieve", bus.sieve, (eph >= 1 && eph <= 3) ? 4'hF : 4'h0);
        check("pump", bus.pump, e_pump);
        check("inlet_en", bus.inlet_en, eph == 1 ? m_mask : '0);
        check("done", bus.done, eph == 5);
        check("err", bus.err, m_err);
        check("aborted", bus.aborted, m_ab);
        // advance to what the next clock edge must produce, using the inputs held across it
        m_err = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_ab = 1'b0;
        end else if (q.size() == 0) begin
            if (bus.start && bus.ch_mask != 0) begin
                m_mask  = bus.ch_mask;
                m_flush = int'(bus.flush_cycles);
`ifdef KINASE_SEQ_REPEAT_EN
                m_rep   = int'(bus.repeats);
`else
                m_rep   = 0;
`endif
                m_ab    = 1'b0;
                add(1, int'(bus.load_cycles));
                for (int p = 0; p <= m_rep; p++) begin
                    add(2, int'(bus.mix_cycles));
                    add(3, int'(bus.incub_cycles));
                end
                add(4, m_flush);
                add(5, 1);
            end else if (bus.start) m_err = 1'b1;
        end else begin
            cph = q[0].ph;
            void'(q.pop_front());
            if (bus.abort && cph >= 1 && cph <= 3) begin
                q.delete();
                add(4, m_flush);
                add(5, 1);
                m_ab = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_durs(input int l, input int m, input int i, input int f);
        bus.load_cycles  = TIMER_W'(l);
        bus.mix_cycles   = TIMER_W'(m);
        bus.incub_cycles = TIMER_W'(i);
        bus.flush_cycles = TIMER_W'(f);
    endtask

    task automatic wait_phase(input int ph, input string nm);
        for (int i = 0; i < 200 && bus.phase != 3'(ph); i++) tick();
        check(nm, bus.phase, ph);
    endtask

    logic [2:0]        ph_r[24];
    logic [PUMP_W-1:0] pu_r[24];
    logic              bz_r[24];
    logic [PUMP_W-1:0] mix_exp[8] = '{5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1D, 5'h1D, 5'h1D, 5'h1D};
    int                cnt[6];
    int                nb, mi, fl;
    logic              seen, ab;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ch_mask = '0;
`ifdef KINASE_SEQ_REPEAT_EN
        bus.repeats = 4'd0;
`endif
        set_durs(3, 8, 4, 6);
        tick();
        tick();
        check("rst_ctrl", bus.ctrl, 13'h1FFF);
        check("rst_sieve", bus.sieve, 4'h0);
        check("rst_pump", bus.pump, 5'h1F);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_pulses", {bus.done, bus.err, bus.aborted}, 3'b000);
        rst_n = 1'b1;
        tick();

        // nominal run: mask 10, durations 3/8/4/6
        bus.ch_mask = 2'b10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i != 0) tick();
            ph_r[i] = bus.phase;
            pu_r[i] = bus.pump;
            bz_r[i] = bus.busy;
            if (i == 21) check("nom_done_aborted", {bus.done, bus.aborted}, 2'b10);
        end
        nb = 0;
        mi = 0;
        for (int p = 0; p < 6; p++) cnt[p] = 0;
        for (int i = 0; i < 24; i++) begin
            nb += int'(bz_r[i]);
            cnt[ph_r[i]]++;
            if (ph_r[i] == 3'd2) begin
                if (mi < 8) check("nom_mix_pump", pu_r[i], mix_exp[mi]);
                mi++;
            end
        end
        check("nom_busy_cycles", nb, 22);
        check("nom_load_len", cnt[1], 3);
        check("nom_mix_len", mi, 8);
        check("nom_incub_len", cnt[3], 4);
        check("nom_flush_len", cnt[4], 6);
        check("nom_done_len", cnt[5], 1);

        // empty mask rejected, next-cycle start accepted
        bus.ch_mask = 2'b00;
        bus.start = 1'b1;
        tick();
        check("rej_err", bus.err, 1'b1);
        check("rej_phase", bus.phase, 3'd0);
        bus.ch_mask = 2'b01;
        tick();
        check("acc_phase", bus.phase, 3'd1);
        check("acc_err", bus.err, 1'b0);
        check("acc_inlet", bus.inlet_en, 2'b01);
        bus.start = 1'b0;
        wait_phase(0, "acc_back_idle");

        // abort in second MIX cycle, repeat abort inside FLUSH
        set_durs(3, 8, 4, 5);
        bus.ch_mask = 2'b11;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_phase(2, "abt_mix_entry");
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abt_flush_now", bus.phase, 3'd4);
        fl = 1;
        seen = 1'b0;
        ab = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.abort = i == 1;
            if (bus.phase == 3'd4) fl++;
            if (bus.done) begin
                seen = 1'b1;
                ab = bus.aborted;
            end
        end
        bus.abort = 1'b0;
        check("abt_flush_len", fl, 5);
        check("abt_done_seen", seen, 1'b1);
        check("abt_aborted", ab, 1'b1);

        // zero durations, start held while busy, abort together with start in IDLE
        set_durs(0, 0, 0, 0);
        bus.ch_mask = 2'b01;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        nb = 0;
        for (int i = 0; i < 7; i++) begin
            if (i != 0) tick();
            if (i == 3) bus.start = 1'b0;
            check("zero_phase", bus.phase, i < 5 ? i + 1 : 0);
            if (i == 4) check("zero_aborted", bus.aborted, 1'b0);
            nb += int'(bus.busy);
        end
        check("zero_busy_cycles", nb, 5);

        // reset during MIX
        set_durs(2, 6, 2, 2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_phase(2, "rst_mix_entry");
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_phase", bus.phase, 3'd0);
        check("midrst_ctrl", bus.ctrl, 13'h1FFF);
        check("midrst_pump", bus.pump, 5'h1F);
        check("midrst_busy_inlet", {bus.busy, bus.inlet_en}, 3'b000);
        rst_n = 1'b1;
        tick();

`ifdef KINASE_SEQ_REPEAT_EN
        // two extra passes: MIX entered three times before FLUSH
        set_durs(1, 2, 1, 1);
        bus.repeats = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        mi = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.phase == 3'd2 && (i == 0 || ph_r[0] != 3'd2)) mi++;
            ph_r[0] = bus.phase;
            tick();
        end
        check("rep_mix_passes", mi, 3);
        bus.repeats = 4'd0;
`endif

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule

// File: doc/kinase_array_sequencer.md
Name: kinase_array_sequencer

Overview:
Digital valve sequencer for an N-channel kinase activity assay array, where all channels share one set of control, sieve and pump valves. Each channel has its own gated sample inlet. On a start request it runs a timed cycle: LOAD, MIX (peristaltic pumping), INCUBATE, FLUSH, DONE. It drives the shared c/s/p valve lines and a per-channel inlet enable, and sits between the host controller and the pneumatic solenoid bank.

Parameters:
NUM_CH, 2, number of assay channels (1..16)
TIMER_W, 16, width of phase duration inputs and internal timer
PUMP_W, 5, number of peristaltic pump valves (>=3)
PUMP_DIV, 4, clock cycles per pump pattern step (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  request a new assay cycle; honoured only in IDLE
abort  in  1  abort the running cycle
ch_mask  in  NUM_CH  channels whose inlets open during LOAD
load_cycles  in  TIMER_W  LOAD duration
mix_cycles  in  TIMER_W  MIX duration
incub_cycles  in  TIMER_W  INCUBATE duration
flush_cycles  in  TIMER_W  FLUSH duration
ctrl  out  13  control valves c1..c13 (bit0=c1); 1 = actuated/closed
sieve  out  4  sieve valves s1..s4; 1 = actuated
pump  out  PUMP_W  pump valves p1..pN; 1 = actuated/closed
inlet_en  out  NUM_CH  per-channel sample inlet open
busy  out  1  high in every state except IDLE
phase  out  3  0 IDLE, 1 LOAD, 2 MIX, 3 INCUBATE, 4 FLUSH, 5 DONE
done  out  1  one-cycle pulse in the DONE state
aborted  out  1  valid with done; 1 if the cycle was aborted
err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values: state IDLE; ctrl=13'h1FFF; sieve=4'h0; pump=all ones; inlet_en=0; busy=0; phase=0; done=0; aborted=0; err=0.
- Reset asserted mid-cycle: IDLE values appear at the next edge. No flush runs.
- Start handling:
  - A start sampled in IDLE with ch_mask!=0 latches ch_mask and all four durations. Outputs show LOAD on the following cycle (1-cycle latency).
  - start with ch_mask==0: err pulses for 1 cycle; the block stays in IDLE.
  - start outside IDLE is ignored, with no err.
- Phase length: each phase lasts exactly D cycles, where D is its latched duration; D=0 is treated as 1. Inputs changed mid-run have no effect.
- Valve patterns per state:
  - IDLE and DONE: ctrl 1FFF, sieve 0, pump all ones, inlet_en 0.
  - LOAD: ctrl 1FF0 (c1..c4 open), sieve F, pump all ones, inlet_en = latched mask.
  - MIX: ctrl 1E0F (c5..c9 open), sieve F, pump rotating, inlet_en 0.
  - INCUBATE: ctrl 1FFF, sieve F, pump all ones, inlet_en 0.
  - FLUSH: ctrl 01FF (c10..c13 open), sieve 0, pump rotating, inlet_en 0.
- Pump rotation:
  - On entry to MIX or FLUSH, pump = all ones except bit0 = 0.
  - Every PUMP_DIV cycles the zero bit rotates left one position, wrapping from bit PUMP_W-1 back to bit0.
  - The divider restarts on each phase entry.
- Transitions: IDLE->LOAD->MIX->INCUBATE->FLUSH->DONE->IDLE. DONE lasts exactly 1 cycle with done=1.
- Abort:
  - abort sampled in LOAD, MIX or INCUBATE moves to FLUSH next cycle with a full flush_cycles duration, and sets the aborted flag.
  - abort in FLUSH, DONE or IDLE is ignored.
  - If abort and the phase-end condition coincide, abort wins.
  - aborted is cleared on the next accepted start.
- Simultaneous start and abort in IDLE: start is honoured and abort is ignored.

Optional Feature:
Macro KINASE_SEQ_REPEAT_EN.
- Defined: adds input port repeat (4 bits), latched at start. After INCUBATE the sequencer returns to MIX repeat times before going to FLUSH, so repeat=0 gives a single pass. An internal pass counter resets at start, and abort overrides any remaining passes.
- Not defined: no repeat port and a single MIX/INCUBATE pass.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> ctrl=1FFF, sieve=0, pump=1F, busy=0, all pulses 0.
- NUM_CH=2, ch_mask=2'b10, durations 3/8/4/6, PUMP_DIV=4 -> phase sequence is LOAD 3 cycles with inlet_en=10, MIX 8 cycles with pump 1E,1E,1E,1E,1D,1D,1D,1D, INCUBATE 4, FLUSH 6, then a 1-cycle done with aborted=0; 22 busy cycles in total including DONE.
- start with ch_mask=0 -> err pulses once, phase stays 0; a start on the next cycle with mask 01 is accepted.
- abort in cycle 2 of MIX (flush_cycles=5) -> FLUSH next cycle for 5 cycles, then done=1 with aborted=1; a second abort during FLUSH does not restart the timer.
- All durations 0 -> each phase lasts 1 cycle, busy for 5 cycles; start reasserted while busy is ignored.
- With KINASE_SEQ_REPEAT_EN, repeat=2 -> MIX/INCUBATE occurs 3 times before FLUSH; rst_n low during the second MIX -> IDLE values on the next edge.
